// File: rtl/de_hazard_ctrl_if.sv
// de_hazard_ctrl_if: decode/issue handshake bundle between decode control and its surrounding pipeline
interface de_hazard_ctrl_if #(
  parameter int CS_W = 23
);
  logic [15:0]     de_ir;
  logic            de_valid;
  logic [CS_W-1:0] cs_bits;
  logic [5:0]      cs_addr;
  logic            agex_ready;
  logic            wb_valid;
  logic [2:0]      wb_dr;
  logic            br_resolved;
  logic            issue;
  logic [2:0]      de_dr;
  logic            de_stall;
  logic            fetch_hold;
  logic            sb_err;
  modport master (
    output de_ir, de_valid, cs_bits, agex_ready, wb_valid, wb_dr, br_resolved,
    input  cs_addr, issue, de_dr, de_stall, fetch_hold, sb_err
  );
  modport slave (
    input  de_ir, de_valid, cs_bits, agex_ready, wb_valid, wb_dr, br_resolved,
    output cs_addr, issue, de_dr, de_stall, fetch_hold, sb_err
  );
endinterface

// File: rtl/de_hazard_ctrl.sv
// de_hazard_ctrl: decode-stage issue gating with per-register write scoreboard and control-flow fetch hold
module de_hazard_ctrl #(
  parameter int CS_W      = 23,
  parameter int LDREG_BIT = 12,
  parameter int DR7_BIT   = 11,
  parameter int SR1_BIT   = 10,
  parameter int SR2_BIT   = 9,
  parameter int SR3_BIT   = 8,
  parameter int CF_BIT    = 7,
  parameter int MAX_INFL  = 3
) (
  input logic clk,
  input logic rst,
  de_hazard_ctrl_if.slave bus
);
  typedef enum logic {RUN, CF_WAIT} state_t;
  localparam logic [1:0] MAXC = 2'(MAX_INFL);
  state_t          state_q;
  logic [7:0][1:0] cnt_q, cnt_d;
  logic            sb_err_q, sb_err_d;
  logic [7:0]      inc_v, dec_v;
  logic [2:0]      de_dr;
  logic            run, ldreg, cf, hazard, issue;
  assign run    = state_q == RUN;
  assign ldreg  = bus.cs_bits[LDREG_BIT];
  assign cf     = bus.cs_bits[CF_BIT];
  assign de_dr  = bus.cs_bits[DR7_BIT] ? 3'd7 : bus.de_ir[11:9];
  assign hazard = (bus.cs_bits[SR1_BIT] & (cnt_q[bus.de_ir[8:6]] != 2'd0))
                | (bus.cs_bits[SR2_BIT] & ~bus.de_ir[5] & (cnt_q[bus.de_ir[2:0]] != 2'd0))
                | (bus.cs_bits[SR3_BIT] & (cnt_q[bus.de_ir[11:9]] != 2'd0))
                | (ldreg & (cnt_q[de_dr] == MAXC));
  assign issue  = ~rst & run & bus.de_valid & ~hazard & bus.agex_ready;
  assign inc_v  = (issue & ldreg) ? 8'd1 << de_dr : 8'd0;
  assign dec_v  = bus.wb_valid ? 8'd1 << bus.wb_dr : 8'd0;
  assign bus.cs_addr    = {bus.de_ir[15:12], bus.de_ir[5], bus.de_ir[11]};
  assign bus.de_dr      = de_dr;
  assign bus.issue      = issue;
  assign bus.de_stall   = ~rst & run & bus.de_valid & ~issue;
  assign bus.fetch_hold = ~rst & (~run | (bus.de_valid & cf));
  assign bus.sb_err     = sb_err_q;
  // next scoreboard counts: inc/dec on the same register cancel; underflow and overflow saturate and flag
  always_comb begin
    cnt_d    = cnt_q;
    sb_err_d = sb_err_q;
    for (int r = 0; r < 8; r++) begin
      cnt_d[r] = (inc_v[r] == dec_v[r]) ? cnt_q[r]
               : inc_v[r] ? ((cnt_q[r] == MAXC) ? cnt_q[r] : cnt_q[r] + 2'd1)
               : ((cnt_q[r] == 2'd0) ? 2'd0 : cnt_q[r] - 2'd1);
      sb_err_d = sb_err_d | (inc_v[r] & ~dec_v[r] & (cnt_q[r] == MAXC))
                          | (dec_v[r] & ~inc_v[r] & (cnt_q[r] == 2'd0));
    end
  end
  // control-flow FSM, scoreboard and sticky error register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      sb_err_q <= 1'b0;
    end else begin
      state_q  <= run ? ((issue & cf) ? CF_WAIT : RUN) : (bus.br_resolved ? RUN : CF_WAIT);
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end
endmodule

// File: tb/tb_de_hazard_ctrl.sv
// tb_de_hazard_ctrl: directed vectors against de_hazard_ctrl with hand-computed expectations
module tb_de_hazard_ctrl;
  localparam logic [22:0] CS_ADD = 23'h001600;
  localparam logic [22:0] CS_BR  = 23'h000080;
  localparam logic [22:0] CS_DR7 = 23'h001800;
  logic clk, rst;
  int   n_vec, n_err;
  de_hazard_ctrl_if #(.CS_W(23)) bus ();
  de_hazard_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic drv(input logic [15:0] ir, input logic v, input logic [22:0] cs, input logic rdy,
                     input logic wv, input logic [2:0] wd, input logic br);
    bus.de_ir       = ir;
    bus.de_valid    = v;
    bus.cs_bits     = cs;
    bus.agex_ready  = rdy;
    bus.wb_valid    = wv;
    bus.wb_dr       = wd;
    bus.br_resolved = br;
    #1;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    drv(16'h0000, 0, '0, 0, 0, 0, 0);
    #1;
    drv(16'h0E05, 1, CS_BR, 1, 0, 0, 0);
    chk("rst_issue", 16'(bus.issue), 16'd0);
    chk("rst_stall", 16'(bus.de_stall), 16'd0);
    chk("rst_fhold", 16'(bus.fetch_hold), 16'd0);
    drv(16'h0000, 0, '0, 1, 0, 0, 0);
    step;
    rst = 1'b0;
    #1;
    chk("rst_cnt", 16'(dut.cnt_q), 16'd0);
    chk("rst_err", 16'(bus.sb_err), 16'd0);
    drv(16'h1283, 1, CS_ADD, 1, 0, 0, 0);
    chk("t1_issue_r1", 16'(bus.issue), 16'd1);
    chk("t1_dr", 16'(bus.de_dr), 16'd1);
    step;
    chk("t1_cnt1", 16'(dut.cnt_q[1]), 16'd1);
    drv(16'h1443, 1, CS_ADD, 1, 0, 0, 0);
    chk("t1_raw_stall", 16'(bus.de_stall), 16'd1);
    chk("t1_raw_issue", 16'(bus.issue), 16'd0);
    step;
    chk("t1_raw_stall2", 16'(bus.de_stall), 16'd1);
    drv(16'h1443, 1, CS_ADD, 1, 1, 1, 0);
    chk("t1_nobypass", 16'(bus.de_stall), 16'd1);
    step;
    chk("t1_cnt1_clr", 16'(dut.cnt_q[1]), 16'd0);
    drv(16'h1443, 1, CS_ADD, 1, 0, 0, 0);
    chk("t1_issue_after_wb", 16'(bus.issue), 16'd1);
    step;
    chk("t1_cnt2", 16'(dut.cnt_q[2]), 16'd1);
    drv(16'h0000, 0, '0, 1, 1, 2, 0);
    step;
    chk("t1_cnt2_clr", 16'(dut.cnt_q[2]), 16'd0);
    drv(16'h1883, 1, CS_ADD, 1, 0, 0, 0);
    chk("t2_issue", 16'(bus.issue), 16'd1);
    step;
    chk("t2_cnt4", 16'(dut.cnt_q[4]), 16'd1);
    drv(16'h1883, 1, CS_ADD, 1, 1, 4, 0);
    chk("t2_issue_wb", 16'(bus.issue), 16'd1);
    step;
    chk("t2_cnt4_same", 16'(dut.cnt_q[4]), 16'd1);
    chk("t2_err", 16'(bus.sb_err), 16'd0);
    drv(16'h0000, 0, '0, 1, 1, 4, 0);
    step;
    chk("t2_cnt4_clr", 16'(dut.cnt_q[4]), 16'd0);
    for (int i = 0; i < 3; i++) begin
      drv(16'h1A25, 1, CS_ADD, 1, 0, 0, 0);
      chk("t3_issue", 16'(bus.issue), 16'd1);
      step;
    end
    chk("t3_cnt5_full", 16'(dut.cnt_q[5]), 16'd3);
    drv(16'h1A25, 1, CS_ADD, 1, 0, 0, 0);
    chk("t3_full_issue", 16'(bus.issue), 16'd0);
    chk("t3_full_stall", 16'(bus.de_stall), 16'd1);
    drv(16'h1A25, 1, CS_ADD, 1, 1, 5, 0);
    chk("t3_full_wb_issue", 16'(bus.issue), 16'd0);
    step;
    chk("t3_cnt5_dec", 16'(dut.cnt_q[5]), 16'd2);
    drv(16'h1A25, 1, CS_ADD, 1, 0, 0, 0);
    chk("t3_issue4", 16'(bus.issue), 16'd1);
    step;
    chk("t3_cnt5_refull", 16'(dut.cnt_q[5]), 16'd3);
    for (int i = 0; i < 3; i++) begin
      drv(16'h0000, 0, '0, 1, 1, 5, 0);
      step;
    end
    chk("t3_cnt5_drain", 16'(dut.cnt_q[5]), 16'd0);
    chk("t3_err", 16'(bus.sb_err), 16'd0);
    drv(16'h0E05, 1, CS_BR, 1, 0, 0, 0);
    chk("t4_br_issue", 16'(bus.issue), 16'd1);
    chk("t4_br_fhold", 16'(bus.fetch_hold), 16'd1);
    step;
    for (int i = 0; i < 5; i++) begin
      drv(16'h1283, 1, CS_ADD, 1, 0, 0, 0);
      chk("t4_wait_issue", 16'(bus.issue), 16'd0);
      chk("t4_wait_fhold", 16'(bus.fetch_hold), 16'd1);
      chk("t4_wait_stall", 16'(bus.de_stall), 16'd0);
      step;
    end
    drv(16'h1283, 1, CS_ADD, 1, 0, 0, 1);
    chk("t4_pulse_fhold", 16'(bus.fetch_hold), 16'd1);
    chk("t4_pulse_issue", 16'(bus.issue), 16'd0);
    step;
    drv(16'h1283, 1, CS_ADD, 1, 0, 0, 0);
    chk("t4_resume_fhold", 16'(bus.fetch_hold), 16'd0);
    chk("t4_resume_issue", 16'(bus.issue), 16'd1);
    step;
    drv(16'h0000, 0, '0, 1, 1, 1, 1);
    step;
    drv(16'h1283, 1, CS_ADD, 1, 0, 0, 0);
    chk("t4_br_in_run", 16'(bus.issue), 16'd1);
    step;
    drv(16'h0000, 0, '0, 1, 1, 6, 0);
    step;
    chk("t5_err_set", 16'(bus.sb_err), 16'd1);
    chk("t5_cnt6", 16'(dut.cnt_q[6]), 16'd0);
    drv(16'h0000, 0, '0, 1, 0, 0, 0);
    step;
    step;
    chk("t5_err_held", 16'(bus.sb_err), 16'd1);
    chk("t5_cnt1_live", 16'(dut.cnt_q[1]), 16'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_err_async", 16'(bus.sb_err), 16'd0);
    chk("t5_cnt_async", 16'(dut.cnt_q), 16'd0);
    step;
    rst = 1'b0;
    drv(16'h1A63, 1, CS_ADD, 0, 0, 0, 0);
    chk("t6_cs_addr", 16'(bus.cs_addr), 16'h0007);
    chk("t6_dr", 16'(bus.de_dr), 16'd5);
    chk("t6_issue", 16'(bus.issue), 16'd0);
    chk("t6_stall", 16'(bus.de_stall), 16'd1);
    step;
    chk("t6_cnt", 16'(dut.cnt_q), 16'd0);
    drv(16'h1A63, 1, CS_DR7, 0, 0, 0, 0);
    chk("t6_dr7", 16'(bus.de_dr), 16'd7);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
